// File: rtl/iob_timer_mc_pkg.sv
// rtl/iob_timer_mc_pkg.sv - register map and control bit positions for iob_timer_mc
package iob_timer_mc_pkg;

  localparam int REG_IDX_W = 3;

  localparam logic [REG_IDX_W-1:0] REG_CTRL   = 3'd0;
  localparam logic [REG_IDX_W-1:0] REG_RLD_LO = 3'd1;
  localparam logic [REG_IDX_W-1:0] REG_RLD_HI = 3'd2;
  localparam logic [REG_IDX_W-1:0] REG_SAMPLE = 3'd3;
  localparam logic [REG_IDX_W-1:0] REG_CNT_LO = 3'd4;
  localparam logic [REG_IDX_W-1:0] REG_CNT_HI = 3'd5;
  localparam logic [REG_IDX_W-1:0] REG_STATUS = 3'd6;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_SRST    = 3;

  localparam int STAT_EXPIRED = 0;

endpackage

// File: rtl/iob_timer_ch.sv
// rtl/iob_timer_ch.sv - one down-counting timer channel with reload, shadow sample and sticky expiry
module iob_timer_ch
  import iob_timer_mc_pkg::*;
#(
  parameter int CNT_W  = 64,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_i,
  input  logic [REG_IDX_W-1:0] reg_i,
  input  logic [DATA_W-1:0]    wdata_i,
  output logic [DATA_W-1:0]    rdata_o,
  output logic                 irq_o
);

  localparam int HI_W = CNT_W - DATA_W;

  logic             en_q, en_d;
  logic             oneshot_q, oneshot_d;
  logic             irq_en_q, irq_en_d;
  logic             expired_q, expired_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;

  logic wr_ctrl, wr_rld_lo, wr_rld_hi, wr_sample, wr_status;
  logic expire;

  assign wr_ctrl   = wr_i && (reg_i == REG_CTRL);
  assign wr_rld_lo = wr_i && (reg_i == REG_RLD_LO);
  assign wr_rld_hi = wr_i && (reg_i == REG_RLD_HI);
  assign wr_sample = wr_i && (reg_i == REG_SAMPLE);
  assign wr_status = wr_i && (reg_i == REG_STATUS);

  assign expire = en_q && (count_q == '0);

  // Next-state: counting/expiry first, then bus writes override where they apply
  always_comb begin
    en_d      = en_q;
    oneshot_d = oneshot_q;
    irq_en_d  = irq_en_q;
    expired_d = expired_q;
    reload_d  = reload_q;
    count_d   = count_q;
    shadow_d  = shadow_q;

    if (en_q) begin
      if (expire) begin
        expired_d = 1'b1;
        if (oneshot_q) en_d = 1'b0;
        else           count_d = reload_q;
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end

    // A fresh expiry beats a simultaneous clear so no event is lost
    if (wr_status && wdata_i[STAT_EXPIRED] && !expire) expired_d = 1'b0;

    if (wr_rld_lo) reload_d[DATA_W-1:0]     = wdata_i;
    if (wr_rld_hi) reload_d[CNT_W-1:DATA_W] = wdata_i[HI_W-1:0];
    if (wr_sample) shadow_d = count_q;

    if (wr_ctrl) begin
      if (wdata_i[CTRL_SRST]) begin
        count_d   = '0;
        expired_d = 1'b0;
        en_d      = 1'b0;
      end else begin
        en_d      = wdata_i[CTRL_EN];
        oneshot_d = wdata_i[CTRL_ONESHOT];
        irq_en_d  = wdata_i[CTRL_IRQ_EN];
        if (wdata_i[CTRL_EN] && !en_q)      count_d = reload_q;
        else if (!wdata_i[CTRL_EN] && en_q) count_d = count_q;
      end
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
      irq_en_q  <= 1'b0;
      expired_q <= 1'b0;
      reload_q  <= '0;
      count_q   <= '0;
      shadow_q  <= '0;
    end else begin
      en_q      <= en_d;
      oneshot_q <= oneshot_d;
      irq_en_q  <= irq_en_d;
      expired_q <= expired_d;
      reload_q  <= reload_d;
      count_q   <= count_d;
      shadow_q  <= shadow_d;
    end
  end

  // Eight-word read mux; write-only and unused slots read zero
  always_comb begin
    rdata_o = '0;
    case (reg_i)
      REG_CTRL: begin
        rdata_o[CTRL_EN]      = en_q;
        rdata_o[CTRL_ONESHOT] = oneshot_q;
        rdata_o[CTRL_IRQ_EN]  = irq_en_q;
      end
      REG_RLD_LO: rdata_o = reload_q[DATA_W-1:0];
      REG_RLD_HI: rdata_o[HI_W-1:0] = reload_q[CNT_W-1:DATA_W];
      REG_CNT_LO: rdata_o = shadow_q[DATA_W-1:0];
      REG_CNT_HI: rdata_o[HI_W-1:0] = shadow_q[CNT_W-1:DATA_W];
      REG_STATUS: rdata_o[STAT_EXPIRED] = expired_q;
      default:    rdata_o = '0;
    endcase
  end

  assign irq_o = expired_q & irq_en_q;

endmodule

// File: rtl/iob_timer_mc.sv
// rtl/iob_timer_mc.sv - multi-channel down-counting timer on the native iob slave bus
module iob_timer_mc
  import iob_timer_mc_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 64,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  output logic [N_CH-1:0]       irq
);

  localparam int CH_W = ADDR_W - REG_IDX_W;

  logic [CH_W-1:0]      ch_field;
  logic [REG_IDX_W-1:0] reg_idx;
  logic                 is_write;
  logic [DATA_W-1:0]    ch_rdata [N_CH];
  logic [DATA_W-1:0]    rd_sel;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 ready_q;

  assign ch_field = address[ADDR_W-1:REG_IDX_W];
  assign reg_idx  = address[REG_IDX_W-1:0];
  assign is_write = |wstrb;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    iob_timer_ch #(
      .CNT_W  (CNT_W),
      .DATA_W (DATA_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_i    (valid && is_write && (ch_field == CH_W'(g))),
      .reg_i   (reg_idx),
      .wdata_i (wdata),
      .rdata_o (ch_rdata[g]),
      .irq_o   (irq[g])
    );
  end

  // Channel select for reads; indices beyond N_CH fall through to zero
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_field == CH_W'(i)) rd_sel = ch_rdata[i];
    end
    rdata_d = (valid && !is_write) ? rd_sel : '0;
  end

  // Registered response: one cycle after every request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= valid;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_iob_timer_mc.sv
// tb/tb_iob_timer_mc.sv - self-checking bench for iob_timer_mc
module tb_iob_timer_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [5:0]  address;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic [3:0]  irq;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  iob_timer_mc #(.N_CH(4), .CNT_W(64), .DATA_W(32), .ADDR_W(6)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (valid),
    .address (address),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .rdata   (rdata),
    .ready   (ready),
    .irq     (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  typedef struct {
    int          ch;
    int          r;
    bit          wr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One bus transaction; edge_n identifies the clock edge that sampled the request
  task automatic bus(input int ch, input int r, input bit wr, input logic [31:0] d,
                     output logic [31:0] rd, output int edge_n);
    @(negedge clk);
    valid   = 1'b1;
    address = 6'(ch * 8 + r);
    wdata   = d;
    wstrb   = wr ? 4'($urandom_range(1, 15)) : 4'h0;
    @(posedge clk);
    #1;
    edge_n = cyc;
    rd     = rdata;
    chk("ready", {63'd0, ready}, 64'd1);
    valid = 1'b0;
    wstrb = 4'h0;
  endtask

  task automatic wait_irq(input int b, input int limit, output int edge_n);
    edge_n = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (irq[b]) begin
        edge_n = cyc;
        return;
      end
    end
  endtask

  // Reference: state after k edges since the enabling edge, from period arithmetic
  function automatic void model(input logic [63:0] rld, input bit os, input longint k,
                                output logic [63:0] cnt, output bit ex, output bit en);
    logic [63:0] ku;
    ku = 64'(k);
    if (os) begin
      ex  = (ku > rld);
      en  = !ex;
      cnt = ex ? 64'd0 : rld - ku;
    end else begin
      ex  = (ku > rld);
      en  = 1'b1;
      cnt = rld - (ku % (rld + 64'd1));
    end
  endfunction

  vec_t        vecs[16];
  logic [31:0] rd;
  int          e, e0, e2, s;
  logic [63:0] rld, cnt, cnt_hi;
  bit          os, ie, ex, en;

  initial begin
    rst_n = 1'b0; valid = 1'b0; address = '0; wdata = '0; wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_rdata", {32'd0, rdata}, 64'd0);
    chk("reset_irq", {60'd0, irq}, 64'd0);

    // Register access table
    vecs[0]  = '{0, 1, 1'b1, 32'h1234_5678, 32'h0};
    vecs[1]  = '{0, 1, 1'b0, 32'h0,         32'h1234_5678};
    vecs[2]  = '{0, 2, 1'b1, 32'hDEAD_BEEF, 32'h0};
    vecs[3]  = '{0, 2, 1'b0, 32'h0,         32'hDEAD_BEEF};
    vecs[4]  = '{4, 1, 1'b1, 32'hFFFF_FFFF, 32'h0};
    vecs[5]  = '{4, 1, 1'b0, 32'h0,         32'h0};
    vecs[6]  = '{0, 1, 1'b0, 32'h0,         32'h1234_5678};
    vecs[7]  = '{3, 7, 1'b1, 32'h5,         32'h0};
    vecs[8]  = '{3, 7, 1'b0, 32'h0,         32'h0};
    vecs[9]  = '{3, 0, 1'b1, 32'h6,         32'h0};
    vecs[10] = '{3, 0, 1'b0, 32'h0,         32'h6};
    vecs[11] = '{3, 0, 1'b1, 32'hF,         32'h0};
    vecs[12] = '{3, 0, 1'b0, 32'h0,         32'h6};
    vecs[13] = '{3, 6, 1'b0, 32'h0,         32'h0};
    vecs[14] = '{7, 0, 1'b0, 32'h0,         32'h0};
    vecs[15] = '{6, 2, 1'b0, 32'h0,         32'h0};
    for (int i = 0; i < 16; i++) begin
      bus(vecs[i].ch, vecs[i].r, vecs[i].wr, vecs[i].wd, rd, e);
      chk($sformatf("vec%0d", i), {32'd0, rd}, {32'd0, vecs[i].exp});
    end
    chk("vec_irq", {60'd0, irq}, 64'd0);

    // ch0 reload=9 periodic with interrupt
    bus(0, 1, 1, 32'd9, rd, e);
    bus(0, 2, 1, 32'd0, rd, e);
    bus(0, 0, 1, 32'h5, rd, e0);
    wait_irq(0, 40, e);
    chk("t2_first_expiry", 64'(e), 64'(e0 + 10));
    chk("t2_irq_vec", {60'd0, irq}, 64'h1);
    bus(0, 6, 0, 32'h0, rd, e);
    chk("t2_status", {32'd0, rd}, 64'd1);
    bus(0, 6, 1, 32'h1, rd, e);
    chk("t2_irq_cleared", {60'd0, irq}, 64'h0);
    wait_irq(0, 40, e);
    chk("t2_second_expiry", 64'(e), 64'(e0 + 20));
    chk("t2_irq_vec2", {60'd0, irq}, 64'h1);
    bus(0, 0, 1, 32'h8, rd, e);

    // ch1 reload=3 one-shot
    bus(1, 1, 1, 32'd3, rd, e);
    bus(1, 2, 1, 32'd0, rd, e);
    bus(1, 0, 1, 32'h7, rd, e0);
    wait_irq(1, 20, e);
    chk("t3_expiry", 64'(e), 64'(e0 + 4));
    repeat (3) @(posedge clk);
    bus(1, 0, 0, 32'h0, rd, e);
    chk("t3_ctrl_en_off", {32'd0, rd}, 64'h6);
    bus(1, 3, 1, 32'h1, rd, e);
    bus(1, 4, 0, 32'h0, rd, e);
    chk("t3_cnt_lo", {32'd0, rd}, 64'd0);
    bus(1, 6, 1, 32'h1, rd, e);
    wait_irq(1, 15, e);
    chk("t3_no_reexpiry", 64'(e), 64'hFFFF_FFFF_FFFF_FFFF);
    bus(1, 6, 0, 32'h0, rd, e);
    chk("t3_status", {32'd0, rd}, 64'd0);

    // ch2 64-bit reload, atomic sample across the low/high boundary
    bus(2, 1, 1, 32'd5, rd, e);
    bus(2, 2, 1, 32'd1, rd, e);
    bus(2, 0, 1, 32'h1, rd, e0);
    repeat (5) @(posedge clk);
    bus(2, 3, 1, 32'h1, rd, s);
    chk("t4_sample_edge", 64'(s), 64'(e0 + 6));
    bus(2, 4, 0, 32'h0, rd, e);
    chk("t4_cnt_lo", {32'd0, rd}, 64'd0);
    bus(2, 5, 0, 32'h0, rd, e);
    chk("t4_cnt_hi", {32'd0, rd}, 64'd1);
    bus(2, 3, 1, 32'h1, rd, s);
    model(64'h1_0000_0005, 1'b0, longint'(s - 1 - e0), cnt, ex, en);
    bus(2, 4, 0, 32'h0, rd, e);
    chk("t4_cnt_lo2", {32'd0, rd}, {32'd0, cnt[31:0]});
    bus(2, 5, 0, 32'h0, rd, e);
    chk("t4_cnt_hi2", {32'd0, rd}, {32'd0, cnt[63:32]});
    bus(2, 0, 1, 32'h8, rd, e);

    // ch3 reload=0 periodic: clear every cycle loses to set; then soft reset
    bus(3, 1, 1, 32'd0, rd, e);
    bus(3, 2, 1, 32'd0, rd, e);
    bus(3, 0, 1, 32'h5, rd, e);
    for (int i = 0; i < 6; i++) bus(3, 6, 1, 32'h1, rd, e);
    chk("t5_irq_held", {60'd0, irq}, 64'h8);
    bus(3, 6, 0, 32'h0, rd, e);
    chk("t5_status_set_wins", {32'd0, rd}, 64'd1);
    bus(3, 0, 1, 32'h8, rd, e);
    bus(3, 0, 0, 32'h0, rd, e);
    chk("t5_ctrl_after_srst", {32'd0, rd}, 64'h4);
    bus(3, 3, 1, 32'h1, rd, e);
    bus(3, 4, 0, 32'h0, rd, e);
    chk("t5_cnt_after_srst", {32'd0, rd}, 64'd0);
    bus(3, 6, 0, 32'h0, rd, e);
    chk("t5_status_after_srst", {32'd0, rd}, 64'd0);
    chk("t5_irq_after_srst", {60'd0, irq}, 64'h0);

    // Randomized runs against the period model
    for (int it = 0; it < 12; it++) begin
      automatic int ch = int'($urandom_range(0, 3));
      os = 1'($urandom_range(0, 1));
      ie = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        rld = {32'($urandom_range(0, 1000)), 32'($urandom)};
      else
        rld = 64'($urandom_range(0, 25));
      bus(ch, 0, 1, 32'h8, rd, e);
      bus(ch, 1, 1, rld[31:0], rd, e);
      bus(ch, 2, 1, rld[63:32], rd, e);
      bus(ch, 0, 1, {29'd0, ie, os, 1'b1}, rd, e0);
      repeat ($urandom_range(0, 25)) @(posedge clk);
      bus(ch, 3, 1, 32'h1, rd, s);
      model(rld, os, longint'(s - 1 - e0), cnt, ex, en);
      bus(ch, 4, 0, 32'h0, rd, e);
      chk("rnd_cnt_lo", {32'd0, rd}, {32'd0, cnt[31:0]});
      bus(ch, 5, 0, 32'h0, rd, e);
      chk("rnd_cnt_hi", {32'd0, rd}, {32'd0, cnt[63:32]});
      bus(ch, 6, 0, 32'h0, rd, e);
      model(rld, os, longint'(e - 1 - e0), cnt_hi, ex, en);
      chk("rnd_status", {32'd0, rd}, {63'd0, ex});
      model(rld, os, longint'(e - e0), cnt_hi, ex, en);
      chk("rnd_irq", {60'd0, irq}, 64'(4'(ex & ie) << ch));
      bus(ch, 0, 0, 32'h0, rd, e);
      model(rld, os, longint'(e - 1 - e0), cnt_hi, ex, en);
      chk("rnd_ctrl", {32'd0, rd}, {61'd0, ie, os, en});
      bus(ch, 0, 1, 32'h8, rd, e);
    end

    // Asynchronous reset in the middle of activity
    bus(0, 1, 1, 32'd0, rd, e);
    bus(0, 2, 1, 32'd0, rd, e);
    bus(0, 0, 1, 32'h5, rd, e);
    bus(0, 0, 0, 32'h0, rd, e);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", {63'd0, ready}, 64'd0);
    chk("arst_rdata", {32'd0, rdata}, 64'd0);
    chk("arst_irq", {60'd0, irq}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) begin
        bus(c, r, 0, 32'h0, rd, e);
        chk($sformatf("arst_reg_c%0d_r%0d", c, r), {32'd0, rd}, 64'd0);
      end
    end
    chk("arst_irq_after", {60'd0, irq}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
